// File: rtl/rf_operand_fetch_if.sv
// rtl/rf_operand_fetch_if.sv - decode / register-file / writeback / issue signal bundle
interface rf_operand_fetch_if;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_ra1;
    logic [4:0]  id_ra2;
    logic        id_use1;
    logic        id_use2;
    logic        id_wen;
    logic [4:0]  id_wa;
    logic [4:0]  rf_ra1;
    logic [4:0]  rf_ra2;
    logic [31:0] rf_src1;
    logic [31:0] rf_src2;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_wd;
    logic        flush;
    logic        ex_ready;
    logic        issue_valid;
    logic [31:0] issue_src1;
    logic [31:0] issue_src2;
    logic        issue_wen;
    logic [4:0]  issue_wa;

    modport slave (
        input  id_valid, id_ra1, id_ra2, id_use1, id_use2, id_wen, id_wa,
        input  rf_src1, rf_src2, wb_en, wb_addr, wb_wd, flush, ex_ready,
        output id_ready, rf_ra1, rf_ra2,
        output issue_valid, issue_src1, issue_src2, issue_wen, issue_wa
    );

    modport master (
        output id_valid, id_ra1, id_ra2, id_use1, id_use2, id_wen, id_wa,
        output rf_src1, rf_src2, wb_en, wb_addr, wb_wd, flush, ex_ready,
        input  id_ready, rf_ra1, rf_ra2,
        input  issue_valid, issue_src1, issue_src2, issue_wen, issue_wa
    );
endinterface

// File: rtl/rf_operand_fetch.sv
// rtl/rf_operand_fetch.sv - operand fetch with pending-write scoreboard, WB bypass and one-entry issue slot
module rf_operand_fetch #(
    parameter int MAX_PENDING = 3
) (
    input logic             clk,
    input logic             reset,
    rf_operand_fetch_if.slave bus
);
    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PENDING);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [CW-1:0] r_cnt     [32];
    logic [CW-1:0] w_cnt_nxt [32];

    logic        r_issue_valid;
    logic [31:0] r_issue_src1;
    logic [31:0] r_issue_src2;
    logic        r_issue_wen;
    logic [4:0]  r_issue_wa;

    logic        w_eff_wr;
    logic        w_hit1;
    logic        w_hit2;
    logic        w_haz1;
    logic        w_haz2;
    logic        w_full;
    logic        w_ready;
    logic        w_accept;
    logic        w_undo;
    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic        w_inc;
    logic        w_dwb;
    logic        w_dfl;

    assign w_eff_wr = bus.wb_en && (bus.wb_addr != 5'd0);
    assign w_hit1   = w_eff_wr && (bus.wb_addr == bus.id_ra1);
    assign w_hit2   = w_eff_wr && (bus.wb_addr == bus.id_ra2);

    // A single outstanding write retiring this very cycle is satisfied by the bypass.
    assign w_haz1 = bus.id_use1 && (bus.id_ra1 != 5'd0) && (r_cnt[bus.id_ra1] != '0)
                    && !((r_cnt[bus.id_ra1] == ONE) && w_hit1);
    assign w_haz2 = bus.id_use2 && (bus.id_ra2 != 5'd0) && (r_cnt[bus.id_ra2] != '0)
                    && !((r_cnt[bus.id_ra2] == ONE) && w_hit2);
    assign w_full = bus.id_wen && (bus.id_wa != 5'd0) && (r_cnt[bus.id_wa] == MAX_CNT);

    assign w_ready  = !bus.flush && !w_haz1 && !w_haz2 && !w_full
                      && (!r_issue_valid || bus.ex_ready);
    assign w_accept = bus.id_valid && w_ready;
    assign w_undo   = bus.flush && r_issue_valid && r_issue_wen && (r_issue_wa != 5'd0);

    assign w_op1 = (bus.id_ra1 == 5'd0) ? 32'd0 : (w_hit1 ? bus.wb_wd : bus.rf_src1);
    assign w_op2 = (bus.id_ra2 == 5'd0) ? 32'd0 : (w_hit2 ? bus.wb_wd : bus.rf_src2);

    always_comb begin
        w_inc = 1'b0;
        w_dwb = 1'b0;
        w_dfl = 1'b0;
        w_cnt_nxt[0] = '0;
        for (int j = 1; j < 32; j++) begin
            w_inc = w_accept && bus.id_wen && (bus.id_wa == 5'(j));
            w_dwb = w_eff_wr && (bus.wb_addr == 5'(j));
            w_dfl = w_undo && (r_issue_wa == 5'(j));
            w_cnt_nxt[j] = r_cnt[j];
            if (w_inc) begin
                if (!w_dwb && (r_cnt[j] != MAX_CNT))
                    w_cnt_nxt[j] = r_cnt[j] + ONE;
            end else if (w_dwb && w_dfl) begin
                w_cnt_nxt[j] = (r_cnt[j] > ONE) ? (r_cnt[j] - ONE - ONE) : '0;
            end else if (w_dwb || w_dfl) begin
                w_cnt_nxt[j] = (r_cnt[j] != '0) ? (r_cnt[j] - ONE) : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 32; k++)
                r_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 32; k++)
                r_cnt[k] <= w_cnt_nxt[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_issue_valid <= 1'b0;
            r_issue_src1  <= 32'd0;
            r_issue_src2  <= 32'd0;
            r_issue_wen   <= 1'b0;
            r_issue_wa    <= 5'd0;
        end else if (bus.flush) begin
            r_issue_valid <= 1'b0;
        end else if (w_accept) begin
            r_issue_valid <= 1'b1;
            r_issue_src1  <= w_op1;
            r_issue_src2  <= w_op2;
            r_issue_wen   <= bus.id_wen;
            r_issue_wa    <= bus.id_wa;
        end else if (bus.ex_ready) begin
            r_issue_valid <= 1'b0;
        end
    end

    assign bus.id_ready    = w_ready;
    assign bus.rf_ra1      = bus.id_ra1;
    assign bus.rf_ra2      = bus.id_ra2;
    assign bus.issue_valid = r_issue_valid;
    assign bus.issue_src1  = r_issue_src1;
    assign bus.issue_src2  = r_issue_src2;
    assign bus.issue_wen   = r_issue_wen;
    assign bus.issue_wa    = r_issue_wa;
endmodule

// File: tb/tb_rf_operand_fetch.sv
// tb/tb_rf_operand_fetch.sv - directed table-driven bench for rf_operand_fetch
module tb_rf_operand_fetch;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rf_operand_fetch_if bus();

    rf_operand_fetch #(.MAX_PENDING(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int vld; int u1; int ra1; int u2; int ra2; int wen; int wa;
        int unsigned s1; int unsigned s2;
        int wbe; int wba; int unsigned wbd; int fl; int exr;
        int e_rdy; int e_iv; int unsigned e_s1; int unsigned e_s2; int e_wen; int e_wa;
        int c_reg; int e_cnt;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.id_valid = v.vld[0];
        bus.id_use1  = v.u1[0];
        bus.id_ra1   = 5'(v.ra1);
        bus.id_use2  = v.u2[0];
        bus.id_ra2   = 5'(v.ra2);
        bus.id_wen   = v.wen[0];
        bus.id_wa    = 5'(v.wa);
        bus.rf_src1  = v.s1;
        bus.rf_src2  = v.s2;
        bus.wb_en    = v.wbe[0];
        bus.wb_addr  = 5'(v.wba);
        bus.wb_wd    = v.wbd;
        bus.flush    = v.fl[0];
        bus.ex_ready = v.exr[0];
    endtask

    function automatic logic [31:0] cnt_of(input int r);
        return 32'(dut.r_cnt[5'(r)]);
    endfunction

    vec_t idle;
    vec_t w;

    initial begin
        // vld,u1,ra1,u2,ra2,wen,wa, s1,s2, wbe,wba,wbd, fl,exr | e_rdy,e_iv,e_s1,e_s2,e_wen,e_wa, c_reg,e_cnt
        vecs[0]  = '{1,1,1,1,2,1,3, 5,7,             0,0,0,      0,1, 1,1,5,7,1,3,            3,1};
        vecs[1]  = '{1,1,1,0,0,1,4, 11,0,            0,0,0,      0,1, 1,1,11,0,1,4,           4,1};
        vecs[2]  = '{1,1,4,1,1,0,0, 'h99,'h22,       0,0,0,      0,1, 0,0,0,0,0,0,            4,1};
        vecs[3]  = '{1,1,4,1,1,0,0, 'h99,'h22,       1,4,'hDEAD, 0,1, 1,1,'hDEAD,'h22,0,0,    4,0};
        vecs[4]  = '{1,0,0,0,0,1,5, 0,0,             0,0,0,      0,1, 1,1,0,0,1,5,            5,1};
        vecs[5]  = '{1,0,0,0,0,1,5, 0,0,             0,0,0,      0,1, 1,1,0,0,1,5,            5,2};
        vecs[6]  = '{1,0,0,0,0,1,5, 0,0,             0,0,0,      0,1, 1,1,0,0,1,5,            5,3};
        vecs[7]  = '{1,0,0,0,0,1,5, 0,0,             0,0,0,      0,1, 0,0,0,0,0,0,            5,3};
        vecs[8]  = '{1,0,0,0,0,1,5, 0,0,             1,5,'h55,   0,1, 0,0,0,0,0,0,            5,2};
        vecs[9]  = '{1,0,0,0,0,1,5, 0,0,             0,0,0,      0,1, 1,1,0,0,1,5,            5,3};
        vecs[10] = '{1,1,0,1,0,0,0, 'h1234,'h1234,   1,0,'hFFFF, 0,1, 1,1,0,0,0,0,            0,0};
        vecs[11] = '{1,0,1,0,0,1,6, 'h66,0,          0,0,0,      0,1, 1,1,'h66,0,1,6,         6,1};
        vecs[12] = '{1,1,1,0,0,0,0, 'h77,'h78,       0,0,0,      0,0, 0,1,'h66,0,1,6,         6,1};
        vecs[13] = '{1,1,1,0,0,0,0, 'h77,'h78,       0,0,0,      0,0, 0,1,'h66,0,1,6,         6,1};
        vecs[14] = '{1,1,1,0,0,0,0, 'h77,'h78,       0,0,0,      0,0, 0,1,'h66,0,1,6,         6,1};
        vecs[15] = '{1,1,1,0,0,0,0, 'h77,'h78,       0,0,0,      1,0, 0,0,0,0,0,0,            6,0};
        vecs[16] = '{1,0,0,0,0,1,7, 0,0,             0,0,0,      0,1, 1,1,0,0,1,7,            7,1};
        vecs[17] = '{1,0,0,0,0,1,7, 0,0,             1,7,7,      0,1, 1,1,0,0,1,7,            7,1};
        vecs[18] = '{1,0,0,0,0,1,8, 0,0,             0,0,0,      0,1, 1,1,0,0,1,8,            8,1};
        vecs[19] = '{1,0,0,0,0,1,8, 0,0,             0,0,0,      0,1, 1,1,0,0,1,8,            8,2};
        vecs[20] = '{1,0,0,1,8,0,0, 0,'h11,          1,8,'h88,   0,1, 0,0,0,0,0,0,            8,1};
        vecs[21] = '{1,0,0,0,0,1,8, 0,0,             0,0,0,      0,1, 1,1,0,0,1,8,            8,2};
        vecs[22] = '{1,0,0,0,0,1,9, 0,0,             1,8,'h8,    1,0, 0,0,0,0,0,0,            8,0};

        idle = '{0,0,0,0,0,0,0, 0,0, 0,0,0, 0,0, 0,0,0,0,0,0, 0,0};
        drive(idle);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_issue_valid", {31'd0, bus.issue_valid}, 32'd0);
        chk("reset_issue_src1", bus.issue_src1, 32'd0);
        chk("reset_issue_src2", bus.issue_src2, 32'd0);
        chk("reset_issue_wen", {31'd0, bus.issue_wen}, 32'd0);
        chk("reset_issue_wa", {27'd0, bus.issue_wa}, 32'd0);
        chk("reset_cnt3", cnt_of(3), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #4;
            chk($sformatf("v%0d_id_ready", i), {31'd0, bus.id_ready}, 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_rf_ra1", i), {27'd0, bus.rf_ra1}, 32'(vecs[i].ra1));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_issue_valid", i), {31'd0, bus.issue_valid}, 32'(vecs[i].e_iv));
            if (vecs[i].e_iv != 0) begin
                chk($sformatf("v%0d_issue_src1", i), bus.issue_src1, vecs[i].e_s1);
                chk($sformatf("v%0d_issue_src2", i), bus.issue_src2, vecs[i].e_s2);
                chk($sformatf("v%0d_issue_wen", i), {31'd0, bus.issue_wen}, 32'(vecs[i].e_wen));
                chk($sformatf("v%0d_issue_wa", i), {27'd0, bus.issue_wa}, 32'(vecs[i].e_wa));
            end
            chk($sformatf("v%0d_cnt_r%0d", i, vecs[i].c_reg), cnt_of(vecs[i].c_reg), 32'(vecs[i].e_cnt));
        end

        // Mid-operation reset with a valid slot and live counters.
        w = idle;
        w.vld = 1; w.u1 = 1; w.ra1 = 1; w.s1 = 'hABC; w.wen = 1; w.wa = 10; w.exr = 1;
        drive(w);
        @(posedge clk);
        #1;
        chk("pre_reset_issue_valid", {31'd0, bus.issue_valid}, 32'd1);
        chk("pre_reset_issue_src1", bus.issue_src1, 32'hABC);
        chk("pre_reset_cnt10", cnt_of(10), 32'd1);
        w.wa = 11; w.exr = 0;
        drive(w);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(idle);
        chk("mid_reset_issue_valid", {31'd0, bus.issue_valid}, 32'd0);
        chk("mid_reset_issue_src1", bus.issue_src1, 32'd0);
        chk("mid_reset_issue_wen", {31'd0, bus.issue_wen}, 32'd0);
        chk("mid_reset_issue_wa", {27'd0, bus.issue_wa}, 32'd0);
        chk("mid_reset_cnt3", cnt_of(3), 32'd0);
        chk("mid_reset_cnt5", cnt_of(5), 32'd0);
        chk("mid_reset_cnt7", cnt_of(7), 32'd0);
        chk("mid_reset_cnt10", cnt_of(10), 32'd0);
        chk("mid_reset_cnt11", cnt_of(11), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rf_operand_fetch.md
Name: rf_operand_fetch

Overview:
- Decode-side reader of the register-file read/write interface.
- Drives the two read addresses to the register file and captures the returned operands.
- Keeps a per-register scoreboard of outstanding writes and bypasses same-cycle writeback data.
- Presents operands to execute through a one-entry valid/ready output stage, and stalls decode on RAW hazards.

Parameters:
- MAX_PENDING, 3, maximum outstanding writes tracked per architectural register; counter width is clog2(MAX_PENDING+1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  instruction accepted this cycle when id_valid & id_ready
- id_ra1, id_ra2  in  5  source register addresses
- id_use1, id_use2  in  1  source actually read
- id_wen  in  1  instruction writes a register
- id_wa  in  5  destination register address
- rf_ra1, rf_ra2  out  5  read addresses to register file (combinational = id_ra1/id_ra2)
- rf_src1, rf_src2  in  32  register file read data, same cycle
- wb_en  in  1  writeback request valid (same request also goes to the register file)
- wb_addr  in  5  writeback address
- wb_wd  in  32  writeback data
- flush  in  1  discard the output slot and block acceptance this cycle
- ex_ready  in  1  execute consumes the output slot
- issue_valid  out  1  output slot holds an instruction
- issue_src1, issue_src2  out  32  resolved operands
- issue_wen  out  1  registered destination enable
- issue_wa  out  5  registered destination address

Behaviour:
- Reset: all pending counters 0; issue_valid=0; issue_src1/2=0; issue_wen=0; issue_wa=0.
- Register 0: never tracked, never stalls; operands read as 0 regardless of rf_src data or bypass.
- Effective write: wb_en & wb_addr!=0.
- Hazard for source i: id_use_i & ra_i!=0 & cnt[ra_i]!=0, except when cnt[ra_i]==1 and an effective write to ra_i occurs this cycle. In that exception, operand = wb_wd (bypass).
- Without a hazard, operand = wb_wd if an effective write to ra_i occurs this cycle, else rf_src_i.
- Destination-full stall: id_wen & id_wa!=0 & cnt[id_wa]==MAX_PENDING.
- id_ready = !flush & no hazard on either source & no dest-full stall & (!issue_valid | ex_ready). id_ready is meaningful only while id_valid is high.
- Accept: output slot loads operands, id_wen and id_wa in 1 cycle; issue_valid=1 next cycle. Latency is 1 cycle.
- Slot behaviour without accept:
  - Holds, stable, while issue_valid & !ex_ready.
  - Otherwise issue_valid clears on ex_ready.
- Counter update: +1 when accept & id_wen & id_wa!=0; −1 on an effective write.
  - Both on the same register in the same cycle: count unchanged.
  - Decrement at 0 is ignored; count stays 0.
  - Never exceeds MAX_PENDING.
- Flush:
  - issue_valid=0 next cycle.
  - If the flushed slot had issue_wen & issue_wa!=0, that register's count −1. This undo combines with the same-cycle writeback decrement, floor 0.
  - No accept occurs in the flush cycle.
- Reset mid-operation overrides everything: counters and slot cleared next edge.

Test Plan:
- Reset, then issue add r3←r1,r2 with rf_src1=5, rf_src2=7, ex_ready=1 -> next cycle issue_valid=1, src1=5, src2=7, issue_wa=3; cnt[3]=1.
- Issue write r4, then a reader of r4 while no writeback -> id_ready=0. Assert wb_en, wb_addr=4, wb_wd=0xDEAD -> same cycle id_ready=1; next cycle issue_src1=0xDEAD, cnt[4]=0.
- Three outstanding writes to r5 (MAX_PENDING=3), fourth writer of r5 -> id_ready=0 until one wb to r5; then accepted with count back to 3.
- Reader of r0 with rf_src=0x1234, and wb to r0 with 0xFFFF -> issue_src=0, no stall, no counter change.
- Slot holds writer r6, ex_ready=0 for 3 cycles -> outputs stable, id_ready=0. flush=1 -> issue_valid=0, cnt[6] 1→0.
- Same cycle: accept writer r7 (cnt 1) plus wb to r7 -> cnt[7] stays 1. Reset asserted with slot valid -> issue_valid=0, all counts 0.
